wb_rr_arbiter: RTL and testbench

Parametrised N-master Wishbone classic arbiter that shares one RAM-side slave port between NUM_MASTERS requesters (CPU, DMA engines, accelerators). It succeeds the fixed two-master CPU/DMA arbiter with these additions:
- true round-robin fairness;
- bounded burst hold, so a master keeping cyc high retains the bus across beats;
- a per-transaction slave timeout that returns an error to the master.

It sits between the user-project masters and the user RAM in the Caravel user area.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 27 ++
 rtl/wb_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone round-robin arbiter: FSM states and counter sizing.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } state_t;

    // Bits needed to hold 0..max_val; never less than one bit so a disabled feature still elaborates.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Masked round-robin priority encoder: lowest requester above last_grant, else lowest overall.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [N-1:0]  o_winner
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_pool;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (IW'(i) > i_last_grant);
        end
        w_masked = i_req & w_mask;
        w_pool   = (|w_masked) ? w_masked : i_req;
        o_winner = w_pool & (~w_pool + N'(1));
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone classic arbiter with round-robin fairness, bounded burst hold and slave timeout.
// Latency: request seen in IDLE reaches the slave 2 cycles later; slave mux and ack/data return are combinational.
// Backpressure: masters wait with stb/cyc high until granted; slave stalls by withholding ack until the timeout.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BURST_MAX   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_adr_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS*DATA_W-1:0]     m_dat_o,
    output logic                              s_stb_o,
    output logic                              s_cyc_o,
    output logic                              s_we_o,
    output logic [DATA_W/8-1:0]               s_sel_o,
    output logic [DATA_W-1:0]                 s_dat_o,
    output logic [ADDR_W-1:0]                 s_adr_o,
    input  logic                              s_ack_i,
    input  logic [DATA_W-1:0]                 s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BW    = cnt_w(BURST_MAX);
    localparam int TW    = cnt_w(TIMEOUT_CYC);
    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam logic [BW-1:0] HOLD_LIM = BW'(BURST_MAX - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_last;
    logic [BW-1:0]          r_beat;
    logic [TW-1:0]          r_to;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_winner;
    logic [IW-1:0]          w_win_idx;
    logic                   w_busy;
    logic                   w_gcyc;
    logic                   w_ack;
    logic                   w_tmo;
    logic                   w_hold;

    assign w_req = m_cyc_i & m_stb_i;

    rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_winner[i]) w_win_idx = IW'(i);
        end
    end

    // Reset asserted mid-tenure already silences the slave side and the return path.
    assign w_busy = (r_state == BUSY) && !wb_rst_i;
    assign w_gcyc = |(m_cyc_i & r_grant);
    assign w_ack  = w_busy && w_gcyc && s_ack_i;
    assign w_tmo  = TO_EN && w_busy && w_gcyc && !s_ack_i && (r_to == TO_LAST);
    assign w_hold = (r_beat < HOLD_LIM);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (|w_req) w_state_nxt = ARB;
            ARB:  w_state_nxt = BUSY;
            BUSY: begin
                if (!w_gcyc)     w_state_nxt = IDLE;
                else if (w_ack)  w_state_nxt = w_hold ? BUSY : IDLE;
                else if (w_tmo)  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_beat  <= '0;
            r_to    <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    r_grant <= w_winner;
                    if (|w_winner) r_last <= w_win_idx;
                    r_beat  <= '0;
                    r_to    <= '0;
                end
                BUSY: begin
                    if (w_state_nxt != BUSY) begin
                        r_grant <= '0;
                        r_beat  <= '0;
                        r_to    <= '0;
                    end else if (w_ack) begin
                        r_beat <= (r_beat == '1) ? r_beat : r_beat + BW'(1);
                        r_to   <= '0;
                    end else begin
                        r_to   <= (r_to == '1) ? r_to : r_to + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_dat_o = '0;
        s_adr_o = '0;
        m_dat_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_busy && r_grant[i]) begin
                s_cyc_o = m_cyc_i[i];
                s_stb_o = m_stb_i[i];
                s_we_o  = m_we_i[i];
                s_sel_o = m_sel_i[i*SEL_W +: SEL_W];
                s_dat_o = m_dat_i[i*DATA_W +: DATA_W];
                s_adr_o = m_adr_i[i*ADDR_W +: ADDR_W];
            end
            if (w_ack && r_grant[i]) m_dat_o[i*DATA_W +: DATA_W] = s_dat_i;
        end
    end

    assign m_ack_o = w_ack ? r_grant : '0;
    assign m_err_o = w_tmo ? r_grant : '0;
    assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: vector table, directed corner sequences, randomized model comparison.
module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int BMAX = 4;
    localparam int TMO  = 8;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic [N-1:0]    m_stb_i = '0, m_cyc_i = '0, m_we_i = '0;
    logic [N*SW-1:0] m_sel_i = '0;
    logic [N*DW-1:0] m_dat_i = '0;
    logic [N*AW-1:0] m_adr_i = '0;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic [N*DW-1:0] m_dat_o;
    logic            s_stb_o, s_cyc_o, s_we_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_o;
    logic [AW-1:0]   s_adr_o;
    logic            s_ack_i = 1'b0;
    logic [DW-1:0]   s_dat_i = '0;

    int n_chk = 0;
    int n_err = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .BURST_MAX (BMAX), .TIMEOUT_CYC (TMO)
    ) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m_stb_i (m_stb_i), .m_cyc_i (m_cyc_i), .m_we_i (m_we_i),
        .m_sel_i (m_sel_i), .m_dat_i (m_dat_i), .m_adr_i (m_adr_i),
        .m_ack_o (m_ack_o), .m_err_o (m_err_o), .m_dat_o (m_dat_o),
        .s_stb_o (s_stb_o), .s_cyc_o (s_cyc_o), .s_we_o (s_we_o),
        .s_sel_o (s_sel_o), .s_dat_o (s_dat_o), .s_adr_o (s_adr_o),
        .s_ack_i (s_ack_i), .s_dat_i (s_dat_i), .grant_o (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w,
                         input logic [SW-1:0] sl, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_cyc_i[i] = c;
        m_stb_i[i] = s;
        m_we_i[i]  = w;
        m_sel_i[i*SW +: SW] = sl;
        m_adr_i[i*AW +: AW] = a;
        m_dat_i[i*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
        s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    // Leaves the bench 2 time units after the first post-reset edge, DUT in IDLE.
    task automatic do_reset();
        wb_rst_i = 1'b1;
        clear_inputs();
        @(posedge wb_clk_i); #2;
        wb_rst_i = 1'b0;
    endtask

    // On success returns mid-cycle in the first cycle with grant_o == g.
    task automatic wait_grant(input logic [N-1:0] g, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #2;
            if (grant_o == g) begin
                ok = 1'b1;
                break;
            end
            @(posedge wb_clk_i); #2;
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {s_cyc_o, s_stb_o, s_we_o, s_sel_o};
    endfunction

    typedef struct {
        logic [N-1:0] cyc;
        logic         ack;
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ack;
        logic [N-1:0] e_err;
    } vec_t;

    vec_t tbl[15];

    // Reference model state for the randomized phase.
    int md_phase, md_owner, md_last, md_beats, md_waits;

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_idle();
        md_phase = 0; md_owner = -1; md_beats = 0; md_waits = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] req;
        req = m_cyc_i & m_stb_i;
        if (wb_rst_i) begin
            model_idle();
            md_last = N - 1;
        end else if (md_phase == 0) begin
            if (req != 0) md_phase = 1;
        end else if (md_phase == 1) begin
            md_owner = rr_pick(req, md_last);
            if (md_owner >= 0) md_last = md_owner;
            md_beats = 0; md_waits = 0; md_phase = 2;
        end else begin
            if (md_owner < 0 || !m_cyc_i[md_owner]) model_idle();
            else if (s_ack_i) begin
                md_beats++;
                md_waits = 0;
                if (md_beats >= BMAX) model_idle();
            end else if (md_waits == TMO - 1) model_idle();
            else md_waits++;
        end
    endtask

    initial begin
        bit ok;
        int trace[$];
        int tcyc[$];
        int left[N];
        int busy_n, err_cnt, err_at, err_k, ack_cnt, regrant_k;
        logic [N-1:0] err_val, first_g;
        logic [N-1:0] rc;
        int ack_pct;
        int exp_tr[7] = '{1, 1, 1, 1, 0, 1, 1};

        tbl[0]  = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{3'b111, 1'b1, 3'b001, 3'b001, 3'b000};
        tbl[3]  = '{3'b110, 1'b0, 3'b001, 3'b000, 3'b000};
        tbl[4]  = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[5]  = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[6]  = '{3'b111, 1'b1, 3'b010, 3'b010, 3'b000};
        tbl[7]  = '{3'b101, 1'b0, 3'b010, 3'b000, 3'b000};
        tbl[8]  = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[9]  = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[10] = '{3'b111, 1'b1, 3'b100, 3'b100, 3'b000};
        tbl[11] = '{3'b011, 1'b0, 3'b100, 3'b000, 3'b000};
        tbl[12] = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[13] = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[14] = '{3'b111, 1'b1, 3'b001, 3'b001, 3'b000};

        // Reset with everything asserted: all outputs quiet after the first edge.
        wb_rst_i = 1'b1;
        m_cyc_i = '1; m_stb_i = '1; m_we_i = '1; m_sel_i = '1; m_adr_i = '1; m_dat_i = '1;
        s_ack_i = 1'b1; s_dat_i = 32'hA5A5_5A5A;
        @(posedge wb_clk_i); #4;
        chk("rst_grant", grant_o, 0);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_sctl", ctl_now(), 0);
        chk("rst_sadr", s_adr_o, 0);
        chk("rst_sdat", s_dat_o, 0);
        chk("rst_mdat", m_dat_o, 0);

        // Round-robin rotation, single-beat tenures ended by the master dropping cyc.
        wb_rst_i = 1'b0;
        clear_inputs();
        for (int r = 0; r < 15; r++) begin
            m_cyc_i = tbl[r].cyc;
            m_stb_i = tbl[r].cyc;
            s_ack_i = tbl[r].ack;
            #1;
            chk($sformatf("tbl%0d_grant", r), grant_o, tbl[r].e_grant);
            chk($sformatf("tbl%0d_ack", r), m_ack_o, tbl[r].e_ack);
            chk($sformatf("tbl%0d_err", r), m_err_o, tbl[r].e_err);
            @(posedge wb_clk_i); #2;
        end

        // Burst hold: master 1 wants 6 beats, master 0 joins with one beat.
        do_reset();
        left = '{0, 6, 0};
        s_ack_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 2) left[0] = 1;
            for (int i = 0; i < N; i++) set_m(i, left[i] > 0, left[i] > 0, 1'b0, '0, '0, '0);
            #2;
            for (int i = 0; i < N; i++) begin
                if (m_ack_o[i]) begin
                    trace.push_back(i);
                    tcyc.push_back(k);
                    left[i]--;
                end
            end
            @(posedge wb_clk_i); #2;
        end
        chk("burst_len", trace.size(), 7);
        if (trace.size() == 7) begin
            for (int j = 0; j < 7; j++) chk($sformatf("burst_tr%0d", j), trace[j], exp_tr[j]);
            for (int j = 1; j < 4; j++) chk($sformatf("burst_b2b%0d", j), tcyc[j] - tcyc[0], j);
        end

        // Timeout: slave never acks.
        do_reset();
        set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, '0);
        busy_n = 0; err_cnt = 0; err_at = -1; err_k = -1; ack_cnt = 0; regrant_k = -1; err_val = '0;
        for (int k = 0; k < 18; k++) begin
            #2;
            if (grant_o == 3'b100 && err_cnt == 0) busy_n++;
            if (m_ack_o != 0) ack_cnt++;
            if (m_err_o != 0) begin
                err_cnt++;
                err_val = m_err_o;
                err_at = busy_n;
                err_k = k;
            end
            if (grant_o == 3'b100 && err_cnt > 0 && k > err_k && regrant_k < 0) regrant_k = k;
            @(posedge wb_clk_i); #2;
        end
        chk("tmo_err_cycles", err_cnt, 1);
        chk("tmo_err_val", err_val, 3'b100);
        chk("tmo_err_busy_cycle", err_at, TMO);
        chk("tmo_no_ack", ack_cnt, 0);
        chk("tmo_regrant_gap", regrant_k - err_k, 3);

        // Write by master 0, read back by master 1.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF);
        set_m(1, 1'b0, 1'b0, 1'b0, 4'h3, 32'h0BAD_0000, 32'h1234_5678);
        wait_grant(3'b001, ok);
        chk("wr_grant_seen", ok, 1);
        chk("wr_sadr", s_adr_o, 32'h3800_0010);
        chk("wr_sdat", s_dat_o, 32'hDEAD_BEEF);
        chk("wr_ctl", ctl_now(), 7'b111_1111);
        s_ack_i = 1'b1;
        #1;
        chk("wr_ack", m_ack_o, 3'b001);
        @(posedge wb_clk_i); #2;
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3800_0010, 32'h1234_5678);
        wait_grant(3'b010, ok);
        chk("rd_grant_seen", ok, 1);
        chk("rd_sadr", s_adr_o, 32'h3800_0010);
        chk("rd_ctl", ctl_now(), 7'b110_1111);
        s_dat_i = 32'hDEAD_BEEF;
        s_ack_i = 1'b1;
        #1;
        chk("rd_ack", m_ack_o, 3'b010);
        chk("rd_mdat1", m_dat_o[DW +: DW], 32'hDEAD_BEEF);
        chk("rd_mdat0", m_dat_o[0 +: DW], 0);
        chk("rd_mdat2", m_dat_o[2*DW +: DW], 0);
        @(posedge wb_clk_i); #2;

        // Stray ack in IDLE, then master abort while granted.
        do_reset();
        s_ack_i = 1'b1;
        #2;
        chk("stray_ack", m_ack_o, 0);
        chk("stray_scyc", s_cyc_o, 0);
        @(posedge wb_clk_i); #2;
        s_ack_i = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h40, '0);
        wait_grant(3'b001, ok);
        chk("abort_grant_seen", ok, 1);
        set_m(0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h40, '0);
        s_ack_i = 1'b1;
        #1;
        chk("abort_ack", m_ack_o, 0);
        chk("abort_err", m_err_o, 0);
        @(posedge wb_clk_i); #2;
        s_ack_i = 1'b0;
        #1;
        chk("abort_idle_grant", grant_o, 0);

        // Reset in the middle of a master 1 burst; master 0 must win first afterwards.
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h80, '0);
        s_ack_i = 1'b1;
        s_dat_i = 32'h5555_AAAA;
        wait_grant(3'b010, ok);
        chk("rstb_grant_seen", ok, 1);
        @(posedge wb_clk_i); #2;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #2;
        chk("rstb_grant", grant_o, 0);
        chk("rstb_ack", m_ack_o, 0);
        chk("rstb_err", m_err_o, 0);
        chk("rstb_sctl", ctl_now(), 0);
        chk("rstb_mdat", m_dat_o, 0);
        wb_rst_i = 1'b0;
        s_ack_i = 1'b0;
        m_cyc_i = '1; m_stb_i = '1;
        first_g = '0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (grant_o != 0) begin
                first_g = grant_o;
                break;
            end
            @(posedge wb_clk_i); #2;
        end
        chk("rstb_first_grant", first_g, 3'b001);
        @(posedge wb_clk_i); #2;

        // Randomized traffic against the reference model.
        do_reset();
        model_idle();
        md_last = N - 1;
        rc = '0;
        ack_pct = 0;
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0]    e_grant, e_ack, e_err;
            logic [6:0]      e_ctl;
            logic [AW-1:0]   e_adr;
            logic [DW-1:0]   e_dat;
            logic [N*DW-1:0] e_mdat;
            if (k % 60 == 0) ack_pct = ((k / 60) % 3 == 0) ? 0 : (((k / 60) % 3 == 1) ? 30 : 90);
            wb_rst_i = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) rc[i] = ~rc[i];
                set_m(i, rc[i], $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                      4'($urandom), $urandom, $urandom);
            end
            s_ack_i = ($urandom_range(0, 99) < ack_pct);
            s_dat_i = $urandom;
            #2;
            e_grant = '0; e_ack = '0; e_err = '0; e_ctl = '0; e_adr = '0; e_dat = '0; e_mdat = '0;
            if (md_phase == 2 && md_owner >= 0) begin
                e_grant[md_owner] = 1'b1;
                if (!wb_rst_i) begin
                    e_ctl = {m_cyc_i[md_owner], m_stb_i[md_owner], m_we_i[md_owner],
                             m_sel_i[md_owner*SW +: SW]};
                    e_adr = m_adr_i[md_owner*AW +: AW];
                    e_dat = m_dat_i[md_owner*DW +: DW];
                    if (m_cyc_i[md_owner] && s_ack_i) begin
                        e_ack[md_owner] = 1'b1;
                        e_mdat[md_owner*DW +: DW] = s_dat_i;
                    end
                    if (m_cyc_i[md_owner] && !s_ack_i && md_waits == TMO - 1) e_err[md_owner] = 1'b1;
                end
            end
            chk($sformatf("rnd%0d_grant", k), grant_o, e_grant);
            chk($sformatf("rnd%0d_ack", k), m_ack_o, e_ack);
            chk($sformatf("rnd%0d_err", k), m_err_o, e_err);
            chk($sformatf("rnd%0d_sctl", k), ctl_now(), e_ctl);
            chk($sformatf("rnd%0d_sadr", k), s_adr_o, e_adr);
            chk($sformatf("rnd%0d_sdat", k), s_dat_o, e_dat);
            chk($sformatf("rnd%0d_mdat", k), m_dat_o, e_mdat);
            model_step();
            @(posedge wb_clk_i); #2;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
